program_memory_loader: RTL and testbench
========================================

Name: program_memory_loader

Overview:
- Parametrised instruction memory for the accumulator CPU. Replaces the hard-coded, reset-initialised program store with one that is loaded at run time.
- A byte-serial loader port (fed from the UART/debug unit) assembles instruction words MSB-first and writes them from address 0 upward. Loading ends at the first HALT word.
- The CPU fetch port gives a registered read with 1-cycle latency. Any address outside the loaded program returns HALT.

Parameters:
- NBITS_O, 11, fetch address width
- NBITS_D, 16, instruction word width; must be an integer multiple of NBITS_B
- NBITS_B, 8, loader byte width
- NBITS_OP, 5, opcode field width (top bits of word); opcode 0 = HALT
- CELDAS, 64, memory depth in words; CELDAS <= 2^NBITS_O

Ports:
- i_clk  in  1  clock, all logic on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_load_start  in  1  one-cycle pulse; begins a new program load
- i_load_valid  in  1  loader byte strobe
- i_load_byte  in  NBITS_B  loader byte
- o_load_ready  out  1  high when a byte is accepted this cycle
- o_load_done  out  1  program loaded, fetch enabled
- o_load_err  out  1  overflow: more than CELDAS words before HALT
- o_load_count  out  NBITS_O+1  number of words written (includes HALT word)
- i_rd_en  in  1  fetch enable (low = stall, hold o_Data)
- i_Addr  in  NBITS_O  fetch address
- o_Data  out  NBITS_D  fetched instruction

Behaviour:
- Reset (async): state=S_IDLE; o_Data=0; o_load_done=0; o_load_err=0; o_load_count=0; byte-lane counter=0; shift register=0. Memory array is not cleared; it is RAM-inferable, with no reset on the array.
- States:
  - S_IDLE: ready=0, fetch disabled. i_load_start moves to S_LOAD.
  - S_LOAD: ready=1. Each cycle with i_load_valid shifts i_load_byte into the word register (first byte = MSB). After NBITS_D/NBITS_B bytes, the word is written to memory[o_load_count] on that same edge, count increments, and the lane counter returns to 0.
    - If the written word's top NBITS_OP bits are 0 (HALT): set done=1, go to S_READY.
    - If count reaches CELDAS with no HALT written: set err=1, done=1, go to S_READY. The last word stays as written; addresses >= count still read as HALT.
  - S_READY: ready=0, fetch enabled. i_load_start clears done, err, count and lane counter, then goes to S_LOAD (reload).
- i_load_start in S_LOAD restarts the load (count=0, lane=0, partial word discarded). A byte presented in the same cycle is ignored.
- i_load_valid outside S_LOAD is ignored.
- Fetch, S_READY only:
  - On an edge with i_rd_en=1: o_Data <= (i_Addr < o_load_count) ? memory[i_Addr] : 0.
  - i_rd_en=0: o_Data holds its value.
  - Latency 1 cycle, back-to-back reads every cycle.
- Fetch outside S_READY: o_Data <= 0 on every edge, regardless of i_rd_en. The CPU sees HALT while loading.
- Reset during S_LOAD: immediate S_IDLE; partial word lost; already-written words remain in the array but are unreachable until a new load completes.
- o_load_count compare is unsigned and NBITS_O+1 bits wide, so count=CELDAS=2^NBITS_O is representable.

Test Plan:
- Load 0x10,0x01,0x28,0x02,0x00,0x00 with valid each cycle -> ready=1 throughout; done rises the edge after the 6th byte; count=3; err=0.
- After that load, i_rd_en=1, i_Addr=1 -> o_Data=0x2802 one cycle later. i_Addr=0 -> 0x1001. i_Addr=5 -> 0x0000. Drop i_rd_en with i_Addr=0 -> o_Data stays at previous value.
- Valid gaps: bytes 0x18,gap,0x08,gap,gap,0x00,0x00 -> memory[0]=0x1808, memory[1]=0x0000, count=2. Identical to gap-free result.
- CELDAS=4: load 5 non-HALT words (0x0801..0x0805) -> err=1, done=1 after 4th word, count=4. 5th word's bytes ignored (ready=0). Fetch addr 3 -> 0x0804.
- Assert i_reset asynchronously mid-word (after 1 byte of 2nd word) -> o_Data=0, done=0, count=0 immediately, without waiting for a clock edge. Fetch during S_IDLE returns 0.
- In S_READY, pulse i_load_start, load 0x00,0x00 -> done drops then rises, count=1. Fetch addr 1 -> 0x0000 even though old data remains in the array.

Source files
------------

// File: rtl/program_memory_loader.sv
// rtl/program_memory_loader.sv - run-time loaded instruction memory for the accumulator CPU
// Bytes arrive MSB-first from the loader port; fetch reads as HALT until a program is loaded.
module program_memory_loader #(
  parameter int NBITS_O  = 11,
  parameter int NBITS_D  = 16,
  parameter int NBITS_B  = 8,
  parameter int NBITS_OP = 5,
  parameter int CELDAS   = 64
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_load_start,
  input  logic               i_load_valid,
  input  logic [NBITS_B-1:0] i_load_byte,
  output logic               o_load_ready,
  output logic               o_load_done,
  output logic               o_load_err,
  output logic [NBITS_O:0]   o_load_count,
  input  logic               i_rd_en,
  input  logic [NBITS_O-1:0] i_Addr,
  output logic [NBITS_D-1:0] o_Data
);

  localparam int LANES = NBITS_D / NBITS_B;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int AW    = (CELDAS > 1) ? $clog2(CELDAS) : 1;
  localparam int PW    = (LANES > 1) ? NBITS_D - NBITS_B : 1;
  localparam logic [NBITS_O:0] FULL_CNT = (NBITS_O + 1)'(CELDAS);
  localparam logic [LW-1:0]    LAST_LANE = LW'(LANES - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READY} state_t;

  state_t             state;
  logic [NBITS_D-1:0] mem [CELDAS];
  logic [PW-1:0]      partial_q;
  logic [LW-1:0]      lane_q;
  logic [NBITS_D-1:0] word_next;
  logic               byte_take;
  logic               wr_en;
  logic               is_halt;
  logic [NBITS_O:0]   count_next;

  // Only the bytes still waiting for their successors are kept; the top byte of
  // a word is never needed once the word has been written.
  if (LANES > 1) begin : g_multi_lane
    assign word_next = {partial_q, i_load_byte};
  end else begin : g_single_lane
    assign word_next = i_load_byte;
  end

  always_comb begin
    byte_take  = (state == S_LOAD) && i_load_valid && !i_load_start;
    wr_en      = byte_take && (lane_q == LAST_LANE);
    is_halt    = (word_next[NBITS_D-1 -: NBITS_OP] == '0);
    count_next = o_load_count + (NBITS_O + 1)'(1);
  end

  assign o_load_ready = (state == S_LOAD);

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[o_load_count[AW-1:0]] <= word_next;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= S_IDLE;
      o_Data       <= '0;
      o_load_done  <= 1'b0;
      o_load_err   <= 1'b0;
      o_load_count <= '0;
      lane_q       <= '0;
      partial_q    <= '0;
    end else begin
      if (state == S_READY) begin
        if (i_rd_en)
          o_Data <= ({1'b0, i_Addr} < o_load_count) ? mem[i_Addr[AW-1:0]] : '0;
      end else begin
        o_Data <= '0;
      end

      if (i_load_start) begin
        state        <= S_LOAD;
        o_load_done  <= 1'b0;
        o_load_err   <= 1'b0;
        o_load_count <= '0;
        lane_q       <= '0;
        partial_q    <= '0;
      end else if (byte_take) begin
        if (wr_en) begin
          lane_q       <= '0;
          partial_q    <= '0;
          o_load_count <= count_next;
          if (is_halt) begin
            o_load_done <= 1'b1;
            state       <= S_READY;
          end else if (count_next == FULL_CNT) begin
            o_load_err  <= 1'b1;
            o_load_done <= 1'b1;
            state       <= S_READY;
          end
        end else begin
          lane_q    <= lane_q + LW'(1);
          partial_q <= word_next[PW-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_program_memory_loader.sv
// tb/tb_program_memory_loader.sv - directed bench with fetch scoreboard for program_memory_loader
module tb_program_memory_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_start, a_valid, a_ready, a_done, a_err, a_rd_en;
  logic [7:0]  a_byte;
  logic [11:0] a_count;
  logic [10:0] a_addr;
  logic [15:0] a_data;
  logic        b_start, b_valid, b_ready, b_done, b_err, b_rd_en;
  logic [7:0]  b_byte;
  logic [11:0] b_count;
  logic [10:0] b_addr;
  logic [15:0] b_data;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  program_memory_loader dut_a (
    .i_clk(clk), .i_reset(rst), .i_load_start(a_start), .i_load_valid(a_valid),
    .i_load_byte(a_byte), .o_load_ready(a_ready), .o_load_done(a_done), .o_load_err(a_err),
    .o_load_count(a_count), .i_rd_en(a_rd_en), .i_Addr(a_addr), .o_Data(a_data)
  );

  program_memory_loader #(.CELDAS(4)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_load_start(b_start), .i_load_valid(b_valid),
    .i_load_byte(b_byte), .o_load_ready(b_ready), .o_load_done(b_done), .o_load_err(b_err),
    .o_load_count(b_count), .i_rd_en(b_rd_en), .i_Addr(b_addr), .o_Data(b_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_a();
    a_start = 1'b1; step(); a_start = 1'b0;
  endtask

  task automatic send_a(input logic [7:0] b);
    a_valid = 1'b1; a_byte = b; step(); a_valid = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] b);
    b_valid = 1'b1; b_byte = b; step(); b_valid = 1'b0;
  endtask

  task automatic fetch_a(input logic en, input logic [10:0] addr, input logic [15:0] expv);
    a_rd_en = en; a_addr = addr; exp_q.push_back(expv);
    step();
    check($sformatf("fetch_a en=%0d addr=%0d", en, addr), a_data, exp_q.pop_front());
    a_rd_en = 1'b0;
  endtask

  task automatic fetch_b(input logic [10:0] addr, input logic [15:0] expv);
    b_rd_en = 1'b1; b_addr = addr; exp_q.push_back(expv);
    step();
    check($sformatf("fetch_b addr=%0d", addr), b_data, exp_q.pop_front());
    b_rd_en = 1'b0;
  endtask

  initial begin
    logic [7:0] prog [6];
    prog = '{8'h10, 8'h01, 8'h28, 8'h02, 8'h00, 8'h00};
    rst = 1'b1;
    a_start = 0; a_valid = 0; a_byte = 0; a_rd_en = 0; a_addr = 0;
    b_start = 0; b_valid = 0; b_byte = 0; b_rd_en = 0; b_addr = 0;
    step(); step();
    check("reset ready", a_ready, 0);
    check("reset done", a_done, 0);
    check("reset err", a_err, 0);
    check("reset count", a_count, 0);
    check("reset data", a_data, 0);
    rst = 1'b0;
    step();

    // basic load and fetch
    start_a();
    for (int i = 0; i < 6; i++) begin
      check($sformatf("ready byte%0d", i), a_ready, 1);
      send_a(prog[i]);
      if (i == 4) check("done before last byte", a_done, 0);
    end
    check("load1 done", a_done, 1);
    check("load1 count", a_count, 3);
    check("load1 err", a_err, 0);
    check("load1 ready after", a_ready, 0);
    fetch_a(1, 1, 16'h2802);
    fetch_a(1, 0, 16'h1001);
    fetch_a(1, 5, 16'h0000);
    fetch_a(1, 2, 16'h0000);
    fetch_a(1, 1, 16'h2802);
    fetch_a(0, 0, 16'h2802);

    // valid gaps
    start_a();
    check("reload done cleared", a_done, 0);
    check("reload count cleared", a_count, 0);
    send_a(8'h18); step(); send_a(8'h08); step(); step(); send_a(8'h00); send_a(8'h00);
    check("gap count", a_count, 2);
    check("gap done", a_done, 1);
    fetch_a(1, 2, 16'h0000);
    fetch_a(1, 1, 16'h0000);
    fetch_a(1, 0, 16'h1808);

    // asynchronous reset in S_READY, away from any edge
    #2 rst = 1'b1;
    #1;
    check("async rst data", a_data, 0);
    check("async rst done", a_done, 0);
    check("async rst count", a_count, 0);
    rst = 1'b0;
    step();
    check("idle ready", a_ready, 0);
    fetch_a(1, 0, 16'h0000);

    // reset mid-word
    start_a();
    send_a(8'h10); send_a(8'h01); send_a(8'h20);
    check("midword count", a_count, 1);
    #2 rst = 1'b1;
    #1;
    check("midword rst count", a_count, 0);
    check("midword rst done", a_done, 0);
    check("midword rst ready", a_ready, 0);
    rst = 1'b0;
    step();

    // restart during load drops the partial word and the coincident byte
    start_a();
    send_a(8'h55);
    a_start = 1'b1; a_valid = 1'b1; a_byte = 8'h66; step();
    a_start = 1'b0; a_valid = 1'b0;
    check("restart count", a_count, 0);
    for (int i = 0; i < 6; i++) send_a(prog[i]);
    check("restart load count", a_count, 3);
    fetch_a(1, 1, 16'h2802);
    fetch_a(1, 0, 16'h1001);

    // reload with a lone HALT
    start_a();
    check("halt reload done low", a_done, 0);
    send_a(8'h00); send_a(8'h00);
    check("halt reload done", a_done, 1);
    check("halt reload count", a_count, 1);
    check("halt reload err", a_err, 0);
    send_a(8'h12);
    check("valid ignored in ready", a_count, 1);
    fetch_a(1, 1, 16'h0000);
    fetch_a(1, 0, 16'h0000);

    // overflow on the CELDAS=4 instance
    b_start = 1'b1; step(); b_start = 1'b0;
    for (int w = 1; w <= 4; w++) begin
      send_b(8'h08); send_b(8'(w));
      if (w == 3) begin
        check("ovf done early", b_done, 0);
        check("ovf err early", b_err, 0);
      end
    end
    check("ovf err", b_err, 1);
    check("ovf done", b_done, 1);
    check("ovf count", b_count, 4);
    check("ovf ready", b_ready, 0);
    send_b(8'h08); send_b(8'h05);
    check("ovf extra ignored", b_count, 4);
    fetch_b(3, 16'h0804);
    fetch_b(4, 16'h0000);
    fetch_b(0, 16'h0801);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
